// File: rtl/sftm_job_dispatcher_if.sv
// Handshake bundle between the tile feeder / SFTM core and the job dispatcher.
// The dispatcher sits on the slave modport; whoever feeds tiles and models the
// core (upstream logic or a testbench) sits on the master modport.
interface sftm_job_dispatcher_if #(
  parameter int POF         = 4,
  parameter int PIF         = 12,
  parameter int MULT_WIDTH  = 32,
  parameter int TOTAL_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8
);
  localparam int N      = POF * PIF;
  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);

  // Tile descriptor handshake
  logic                    tile_valid;
  logic                    tile_ready;
  logic [TOTAL_WIDTH-1:0]  tile_mults;
  logic                    tile_last;

  // Job push into the core FIFO
  logic                    job_valid;
  logic [N*MULT_WIDTH-1:0] assigned_mults_flat;

  // Core control and status
  logic                    start;
  logic                    core_busy;
  logic                    core_job_done;
  logic [PEND_W-1:0]       jobs_pending;
  logic                    batch_done;
  logic [15:0]             done_count;

  modport master (
    output tile_valid, tile_mults, tile_last, core_busy, core_job_done,
    input  tile_ready, job_valid, assigned_mults_flat, start,
           jobs_pending, batch_done, done_count
  );

  modport slave (
    input  tile_valid, tile_mults, tile_last, core_busy, core_job_done,
    output tile_ready, job_valid, assigned_mults_flat, start,
           jobs_pending, batch_done, done_count
  );
endinterface

// File: rtl/sftm_job_dispatcher.sv
// Job dispatcher for the SFTM core. Each tile's multiply count is split evenly
// over the POF x PIF SCU grid with a bit-serial restoring divider; the lane
// vector is pushed into the core job FIFO under credit control, start pulses
// are issued while the core is idle, and batch completion is tracked from the
// core's job_done pulses.
module sftm_job_dispatcher #(
  parameter int POF         = 4,
  parameter int PIF         = 12,
  parameter int MULT_WIDTH  = 32,
  parameter int TOTAL_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sftm_job_dispatcher_if.slave  bus
);

  localparam int N      = POF * PIF;
  // Partial remainder is always < N before the shift, so one extra bit holds
  // the shifted trial value.
  localparam int REM_W  = $clog2(N) + 1;
  localparam int CNT_W  = $clog2(TOTAL_WIDTH) + 1;
  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [REM_W-1:0]  N_REM    = REM_W'(N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TOTAL_WIDTH - 1);
  localparam logic [PEND_W-1:0] CREDITS  = PEND_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    init_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [N*MULT_WIDTH-1:0] assigned_q;

  // Divider datapath
  logic [TOTAL_WIDTH-1:0]  dvd_q;
  logic [TOTAL_WIDTH-1:0]  quo_q;
  logic [REM_W-1:0]        rem_q;
  logic [REM_W-1:0]        trial;
  logic                    geq;
  logic [REM_W-1:0]        rem_step;
  logic [TOTAL_WIDTH-1:0]  quo_step;

  // Credit / start tracking
  logic [PEND_W-1:0]       pending_q;
  logic                    start_prev_q;

  // Batch tracking
  logic [15:0]             accepted_q;
  logic [15:0]             completed_q;
  logic                    last_seen_q;
  logic                    batch_done_q;
  logic [15:0]             done_count_q;

  logic                    tile_ready;
  logic                    accept;
  logic                    job_valid;
  logic                    start;
  logic                    batch_close;

  // Lane i gets base+1 for the first rem lanes, base for the rest; the sum is
  // therefore exactly base*N + rem.
  function automatic logic [N*MULT_WIDTH-1:0] spread(
    input logic [TOTAL_WIDTH-1:0] base,
    input logic [REM_W-1:0]       rem
  );
    logic [N*MULT_WIDTH-1:0] lanes;
    logic [MULT_WIDTH-1:0]   b;
    lanes = '0;
    b     = MULT_WIDTH'(base);
    for (int i = 0; i < N; i++) begin
      lanes[i*MULT_WIDTH +: MULT_WIDTH] = (REM_W'(i) < rem) ? (b + MULT_WIDTH'(1)) : b;
    end
    return lanes;
  endfunction

  // A new tile is taken only in IDLE, once out of reset, and never while a
  // closed batch (last tile seen) is still draining.
  assign tile_ready = (state_q == IDLE) && init_q && !last_seen_q;
  assign accept     = bus.tile_valid && tile_ready;

  // A push needs a free FIFO slot; with pending at FIFO_DEPTH the push waits
  // for the cycle after a start returns a credit.
  assign job_valid  = (state_q == PUSH) && (pending_q < CREDITS);

  // The core only raises busy the cycle after start, so back-to-back starts
  // are suppressed to avoid a double FIFO read.
  assign start      = (pending_q != '0) && !bus.core_busy && !start_prev_q;

  // This job_done finishes the batch when it is the last outstanding job of
  // a batch whose final tile has already been accepted.
  assign batch_close = bus.core_job_done && last_seen_q &&
                       ((completed_q + 16'd1) == accepted_q);

  // One restoring-division step: shift in the next dividend bit, subtract N
  // when it fits and record the quotient bit.
  always_comb begin
    trial    = {rem_q[REM_W-2:0], dvd_q[TOTAL_WIDTH-1]};
    geq      = (trial >= N_REM);
    rem_step = geq ? (trial - N_REM) : trial;
    quo_step = {quo_q[TOTAL_WIDTH-2:0], geq};
  end

  // Control FSM: accept a tile, run TOTAL_WIDTH divide steps, then push once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      cnt_q      <= '0;
      assigned_q <= '0;
    end else begin
      init_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            assigned_q <= spread(quo_step, rem_step);
            state_q    <= PUSH;
          end
        end
        PUSH: begin
          if (job_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- divider datapath stage (no reset: state alone qualifies it) ----
  // Load the dividend on accept and iterate while in DIV.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q <= bus.tile_mults;
      quo_q <= '0;
      rem_q <= '0;
    end else if (state_q == DIV) begin
      dvd_q <= {dvd_q[TOTAL_WIDTH-2:0], 1'b0};
      quo_q <= quo_step;
      rem_q <= rem_step;
    end
  end

  // Credit counter: +1 per push, -1 per start, unchanged when both coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start;
      case ({job_valid, start})
        2'b10:   pending_q <= pending_q + PEND_W'(1);
        2'b01:   pending_q <= pending_q - PEND_W'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

  // Batch accounting and the free-running completed-job counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_q   <= '0;
      completed_q  <= '0;
      last_seen_q  <= 1'b0;
      batch_done_q <= 1'b0;
      done_count_q <= '0;
    end else begin
      batch_done_q <= batch_close;
      if (bus.core_job_done) begin
        done_count_q <= done_count_q + 16'd1;
      end
      if (batch_close) begin
        accepted_q  <= '0;
        completed_q <= '0;
        last_seen_q <= 1'b0;
      end else begin
        if (accept) begin
          accepted_q <= accepted_q + 16'd1;
          if (bus.tile_last) begin
            last_seen_q <= 1'b1;
          end
        end
        if (bus.core_job_done) begin
          completed_q <= completed_q + 16'd1;
        end
      end
    end
  end

  assign bus.tile_ready          = tile_ready;
  assign bus.job_valid           = job_valid;
  assign bus.assigned_mults_flat = assigned_q;
  assign bus.start               = start;
  assign bus.jobs_pending        = pending_q;
  assign bus.batch_done          = batch_done_q;
  assign bus.done_count          = done_count_q;

endmodule

// File: tb/tb_sftm_job_dispatcher.sv
// Self-checking bench for sftm_job_dispatcher: directed scenarios plus random
// tile counts, checked against an arithmetic model of the even lane split and
// the documented cycle timing. A small core model answers start pulses.
module tb_sftm_job_dispatcher;

  localparam int POF = 4;
  localparam int PIF = 12;
  localparam int MW  = 32;
  localparam int TW  = 32;
  localparam int FD  = 8;
  localparam int N   = POF * PIF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sftm_job_dispatcher_if #(.POF(POF), .PIF(PIF), .MULT_WIDTH(MW),
                           .TOTAL_WIDTH(TW), .FIFO_DEPTH(FD)) bus ();

  sftm_job_dispatcher #(.POF(POF), .PIF(PIF), .MULT_WIDTH(MW),
                        .TOTAL_WIDTH(TW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log captured mid-cycle
  int unsigned          acc_q[$];
  int unsigned          job_cyc_q[$];
  logic [N*MW-1:0]      job_lane_q[$];
  int unsigned          start_q[$];
  int unsigned          done_q[$];
  int unsigned          bd_q[$];
  bit                   start_last = 1'b0;

  always @(negedge clk) begin
    start_last = bus.start;
    if (bus.tile_valid && bus.tile_ready) acc_q.push_back(cyc);
    if (bus.job_valid) begin
      job_cyc_q.push_back(cyc);
      job_lane_q.push_back(bus.assigned_mults_flat);
    end
    if (bus.start)         start_q.push_back(cyc);
    if (bus.core_job_done) done_q.push_back(cyc);
    if (bus.batch_done)    bd_q.push_back(cyc);
  end

  // Core model: busy the cycle after start, job_done after a short random latency
  bit core_hold = 1'b0;
  int core_cnt  = 0;
  initial begin
    bus.core_busy     = 1'b0;
    bus.core_job_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.core_job_done = 1'b0;
      if (core_hold) begin
        bus.core_busy = 1'b1;
      end else if (start_last) begin
        bus.core_busy = 1'b1;
        core_cnt = $urandom_range(2, 5);
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          bus.core_job_done = 1'b1;
          bus.core_busy     = 1'b0;
        end
      end else begin
        bus.core_busy = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: even split of m over N lanes using plain division
  function automatic logic [N*MW-1:0] model_lanes(input logic [31:0] m);
    logic [N*MW-1:0] v;
    longint unsigned base, r;
    base = longint'(m) / N;
    r    = longint'(m) % N;
    v    = '0;
    for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'(base + ((i < r) ? 1 : 0));
    return v;
  endfunction

  function automatic longint unsigned lane_sum(input logic [N*MW-1:0] v);
    longint unsigned s = 0;
    for (int i = 0; i < N; i++) s += longint'(v[i*MW +: MW]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [N*MW-1:0] obs, input logic [N*MW-1:0] exp);
    int bl = 0;
    for (int i = N - 1; i >= 0; i--) if (obs[i*MW +: MW] !== exp[i*MW +: MW]) bl = i;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s lane %0d observed=%0d expected=%0d", tag, bl, obs[bl*MW +: MW], exp[bl*MW +: MW]);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_tile(input logic [31:0] m, input bit last);
    int k = 0;
    bus.tile_mults = m;
    bus.tile_last  = last;
    bus.tile_valid = 1'b1;
    while (!bus.tile_ready && k < 1000) begin tick(); k++; end
    chk("tile_accept", 64'(bus.tile_ready), 64'd1);
    tick();
    bus.tile_valid = 1'b0;
    bus.tile_last  = 1'b0;
  endtask

  task automatic wait_jobs(input int n);
    int k = 0;
    while (job_cyc_q.size() < n && k < 500) begin tick(); k++; end
    chk("job_seen", 64'(job_cyc_q.size() >= n), 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (!(bus.jobs_pending == 0 && start_q.size() == done_q.size() &&
             core_cnt == 0 && bus.tile_ready) && k < 500) begin tick(); k++; end
    repeat (2) tick();
    chk("drain", 64'(bus.jobs_pending == 0 && start_q.size() == done_q.size()), 64'd1);
  endtask

  task automatic run_tile(input logic [31:0] m, input bit last, input bit timing);
    int j0 = job_cyc_q.size();
    int s0 = start_q.size();
    int k  = 0;
    send_tile(m, last);
    wait_jobs(j0 + 1);
    if (job_cyc_q.size() > j0) begin
      chk_lanes("lanes", job_lane_q[j0], model_lanes(m));
      chk("lane_sum", 64'(lane_sum(job_lane_q[j0])), 64'(m));
      if (timing) begin
        chk("job_latency", 64'(job_cyc_q[j0] - acc_q[$]), 64'(TW + 1));
        while (start_q.size() <= s0 && k < 20) begin tick(); k++; end
        chk("start_seen", 64'(start_q.size() > s0), 64'd1);
        if (start_q.size() > s0) chk("start_gap", 64'(start_q[s0] - job_cyc_q[j0]), 64'd1);
      end
    end
  endtask

  initial begin
    int j0, s0, b0, d0, k;
    logic [31:0] ms[9];
    logic [N*MW-1:0] lv;

    bus.tile_valid = 1'b0;
    bus.tile_mults = '0;
    bus.tile_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_tile_ready",   64'(bus.tile_ready),   64'd0);
    chk("rst_job_valid",    64'(bus.job_valid),    64'd0);
    chk("rst_start",        64'(bus.start),        64'd0);
    chk("rst_batch_done",   64'(bus.batch_done),   64'd0);
    chk("rst_jobs_pending", 64'(bus.jobs_pending), 64'd0);
    chk("rst_done_count",   64'(bus.done_count),   64'd0);
    chk_lanes("rst_lanes", bus.assigned_mults_flat, '0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(bus.tile_ready), 64'd1);

    // Directed split cases with latency and start timing
    run_tile(32'd100, 1'b0, 1'b1);
    lv = job_lane_q[job_lane_q.size() - 1];
    chk("t100_lane0",  64'(lv[0*MW +: MW]),  64'd3);
    chk("t100_lane3",  64'(lv[3*MW +: MW]),  64'd3);
    chk("t100_lane4",  64'(lv[4*MW +: MW]),  64'd2);
    chk("t100_lane47", 64'(lv[47*MW +: MW]), 64'd2);
    drain();
    run_tile(32'hFFFF_FFFF, 1'b0, 1'b1);
    lv = job_lane_q[job_lane_q.size() - 1];
    chk("tmax_lane14", 64'(lv[14*MW +: MW]), 64'd89478486);
    chk("tmax_lane15", 64'(lv[15*MW +: MW]), 64'd89478485);
    drain();
    run_tile(32'd0, 1'b0, 1'b1);
    drain();
    run_tile(32'd47, 1'b0, 1'b1);
    lv = job_lane_q[job_lane_q.size() - 1];
    chk("t47_lane46", 64'(lv[46*MW +: MW]), 64'd1);
    chk("t47_lane47", 64'(lv[47*MW +: MW]), 64'd0);
    drain();

    // Random tile counts against the model
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) run_tile(32'($urandom_range(0, 200)), 1'b0, 1'b0);
      else            run_tile($urandom, 1'b0, 1'b0);
    end
    drain();

    // Credit exhaustion: core held busy, nine tiles offered
    core_hold = 1'b1;
    tick();
    j0 = job_cyc_q.size();
    for (int i = 0; i < 9; i++) begin
      ms[i] = $urandom;
      send_tile(ms[i], 1'b0);
    end
    repeat (40) tick();
    chk("credit_pushes",  64'(job_cyc_q.size() - j0), 64'd8);
    chk("credit_pending", 64'(bus.jobs_pending),      64'(FD));
    chk("credit_stall",   64'(bus.job_valid),         64'd0);
    chk("credit_no_ready", 64'(bus.tile_ready),       64'd0);
    s0 = start_q.size();
    core_hold = 1'b0;
    wait_jobs(j0 + 9);
    if (job_cyc_q.size() >= j0 + 9 && start_q.size() > s0)
      chk("credit_push_after_start", 64'(job_cyc_q[j0 + 8] - start_q[s0]), 64'd1);
    for (int i = 0; i < 9; i++)
      if (job_cyc_q.size() > j0 + i) chk_lanes("credit_lanes", job_lane_q[j0 + i], model_lanes(ms[i]));
    drain();

    // Reset during DIV aborts the tile
    send_tile(32'd1234, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_tile_ready",   64'(bus.tile_ready),   64'd0);
    chk("abort_job_valid",    64'(bus.job_valid),    64'd0);
    chk("abort_start",        64'(bus.start),        64'd0);
    chk("abort_jobs_pending", 64'(bus.jobs_pending), 64'd0);
    chk("abort_done_count",   64'(bus.done_count),   64'd0);
    chk_lanes("abort_lanes", bus.assigned_mults_flat, '0);
    tick();
    rst_n = 1'b1;
    j0 = job_cyc_q.size();
    repeat (60) tick();
    chk("abort_no_job", 64'(job_cyc_q.size() - j0), 64'd0);
    chk("abort_ready",  64'(bus.tile_ready),        64'd1);

    // Batch of three tiles, last flag on the third
    b0 = bd_q.size();
    d0 = done_q.size();
    run_tile($urandom, 1'b0, 1'b0);
    run_tile($urandom, 1'b0, 1'b0);
    run_tile(32'($urandom_range(0, 5000)), 1'b1, 1'b0);
    tick();
    chk("batch_ready_blocked", 64'(bus.tile_ready), 64'd0);
    k = 0;
    while (done_q.size() < d0 + 3 && k < 100) begin tick(); k++; end
    repeat (3) tick();
    chk("batch_done_jobs", 64'(done_q.size() - d0), 64'd3);
    chk("batch_done_count", 64'(bd_q.size() - b0), 64'd1);
    if (bd_q.size() > b0 && done_q.size() >= d0 + 3)
      chk("batch_done_timing", 64'(bd_q[b0] - done_q[d0 + 2]), 64'd1);
    chk("done_count", 64'(bus.done_count), 64'd3);
    chk("batch_ready_again", 64'(bus.tile_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
